// File: rtl/lod_pkg.sv
// ============================================================================
// Module : lod_pkg
// Brief  : Shared types, default sizes and the per-group leading-one helper
//          for the leading-one normalization scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lod_state_e;

  localparam int DEF_DATA_W  = 20;
  localparam int DEF_GROUP_W = 4;

  // Widest group the helper accepts; narrower groups are zero-extended.
  localparam int GRP_MAX_W   = 16;

  // Index of the highest set bit; returns 0 for an all-zero group, so the
  // caller must qualify the result with its own nonzero test.
  function automatic int unsigned group_msb_index(input logic [GRP_MAX_W-1:0] grp);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < GRP_MAX_W; i++) begin
      if (grp[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lod_rr_arbiter.sv
// ============================================================================
// Module : lod_rr_arbiter
// Brief  : Combinational round-robin picker. Starting at ptr_i and wrapping
//          modulo NUM_LANES, selects the first lane with req_i set.
// Ports  : req_i   - per-lane request vector
//          ptr_i   - lane with highest priority this cycle
//          grant_o - one-hot grant (all zero when nothing requests)
//          idx_o   - encoded index of the granted lane
//          any_o   - at least one lane is requesting
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lod_rr_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [LANE_W-1:0]    ptr_i,
  output logic [NUM_LANES-1:0] grant_o,
  output logic [LANE_W-1:0]    idx_o,
  output logic                 any_o
);

  int w_lane;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_lane  = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_lane = (int'(ptr_i) + i) % NUM_LANES;
      if (!any_o && req_i[w_lane]) begin
        any_o           = 1'b1;
        grant_o[w_lane] = 1'b1;
        idx_o           = LANE_W'(w_lane);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lod_norm_scheduler.sv
// ============================================================================
// Module : lod_norm_scheduler
// Brief  : Shared leading-one / normalization front-end. NUM_LANES lanes are
//          arbitrated round-robin; the winning sum is scanned MSB-first one
//          GROUP_W-bit group per cycle, and the leading-one position, zero
//          flag and left-normalized value are returned with the lane id.
// Ports  : clk, rst_n                 - clock, async active-low reset
//          req_valid/req_data/req_ready - per-lane request, one-hot accept
//          out_valid/out_ready        - result handshake
//          out_lane/out_pos/out_zero/out_norm - registered result fields
// Config : LOD_FASTPATH_EN - when defined, a sum whose top group is nonzero
//          is resolved on the grant edge and skips SCAN; all other sums
//          start scanning one group lower. Results are identical.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lod_norm_scheduler
  import lod_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int GROUP_W   = DEF_GROUP_W,
  localparam int NGROUPS   = DATA_W / GROUP_W,
  localparam int POS_W     = $clog2(DATA_W),
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_LANES-1:0]          req_valid,
  input  logic [NUM_LANES*DATA_W-1:0]   req_data,
  output logic [NUM_LANES-1:0]          req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANE_W-1:0]             out_lane,
  output logic [POS_W-1:0]              out_pos,
  output logic                          out_zero,
  output logic [DATA_W-1:0]             out_norm
);

  localparam int c_GRP_W = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  lod_state_e          state_q,  state_d;
  logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LANE_W-1:0]   lane_q,   lane_d;
  logic [DATA_W-1:0]   data_q,   data_d;
  logic [c_GRP_W-1:0]  grp_q,    grp_d;
  logic [POS_W-1:0]    pos_q,    pos_d;
  logic                zero_q,   zero_d;
  logic [DATA_W-1:0]   norm_q,   norm_d;

  logic [NUM_LANES-1:0] w_grant;
  logic [LANE_W-1:0]    w_gnt_idx;
  logic                 w_gnt_any;
  logic [DATA_W-1:0]    w_sel_data;
  logic [GROUP_W-1:0]   w_scan_bits;
  int                   w_scan_base;
  int                   w_scan_pos;

  lod_rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_gnt_idx),
    .any_o   (w_gnt_any)
  );

  // Winning lane's sum, only meaningful while w_gnt_any is set.
  assign w_sel_data  = DATA_W'(req_data >> (int'(w_gnt_idx) * DATA_W));

  // Group currently under examination and its absolute leading-one index.
  assign w_scan_base = int'(grp_q) * GROUP_W;
  assign w_scan_bits = GROUP_W'(data_q >> w_scan_base);
  assign w_scan_pos  = w_scan_base + int'(group_msb_index(GRP_MAX_W'(w_scan_bits)));

`ifdef LOD_FASTPATH_EN
  logic [GROUP_W-1:0] w_top_bits;
  int                 w_top_pos;

  assign w_top_bits = w_sel_data[DATA_W-1 -: GROUP_W];
  assign w_top_pos  = (NGROUPS - 1) * GROUP_W
                    + int'(group_msb_index(GRP_MAX_W'(w_top_bits)));
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lane_d    = lane_q;
    data_d    = data_q;
    grp_d     = grp_q;
    pos_d     = pos_q;
    zero_d    = zero_q;
    norm_d    = norm_q;
    req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (w_gnt_any) begin
          // Gate with rst_n so the accept is also low while reset is held.
          req_ready = w_grant & {NUM_LANES{rst_n}};
          lane_d    = w_gnt_idx;
          data_d    = w_sel_data;
`ifdef LOD_FASTPATH_EN
          if (w_top_bits != '0) begin
            pos_d   = POS_W'(w_top_pos);
            zero_d  = 1'b0;
            norm_d  = w_sel_data << (DATA_W - 1 - w_top_pos);
            state_d = DONE;
          end else if (NGROUPS == 1) begin
            pos_d   = '0;
            zero_d  = 1'b1;
            norm_d  = '0;
            state_d = DONE;
          end else begin
            grp_d   = c_GRP_W'(NGROUPS - 2);
            state_d = SCAN;
          end
`else
          grp_d   = c_GRP_W'(NGROUPS - 1);
          state_d = SCAN;
`endif
        end
      end

      SCAN: begin
        if (w_scan_bits != '0) begin
          pos_d   = POS_W'(w_scan_pos);
          zero_d  = 1'b0;
          norm_d  = data_q << (DATA_W - 1 - w_scan_pos);
          state_d = DONE;
        end else if (grp_q == '0) begin
          pos_d   = '0;
          zero_d  = 1'b1;
          norm_d  = '0;
          state_d = DONE;
        end else begin
          grp_d   = grp_q - c_GRP_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          // Lane after the one just served gets first priority next time.
          rr_ptr_d = (lane_q == LANE_W'(NUM_LANES - 1)) ? '0 : lane_q + LANE_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      lane_q   <= '0;
      data_q   <= '0;
      grp_q    <= '0;
      pos_q    <= '0;
      zero_q   <= 1'b0;
      norm_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lane_q   <= lane_d;
      data_q   <= data_d;
      grp_q    <= grp_d;
      pos_q    <= pos_d;
      zero_q   <= zero_d;
      norm_q   <= norm_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_lane  = lane_q;
  assign out_pos   = pos_q;
  assign out_zero  = zero_q;
  assign out_norm  = norm_q;

endmodule

`default_nettype wire
